// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch path.
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush clears it in one edge.
// Latency: a push is visible at the head on the following cycle (no bypass).
// Backpressure: push is accepted when not full, or when full with a same-cycle pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           pop_ok;
    logic           push_ok;

    // Pop on empty is never requested by the top, but is ignored defensively.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt < CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem combinationally, queues {pc, instr}.
// Latency: pushed entry reaches decode one cycle later; redirect restarts in two.
// Backpressure: decode stalls via out_ready; fetch stalls when the FIFO is full.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    output logic [31:0]                imem_addr,
    input  logic [DATA_WIDTH-1:0]      imem_rd,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [31:0]                out_pc,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic          pop;
    logic          push;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic [CW-1:0] count;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = fetch_en && !redirect && ((count < CW'(DEPTH)) || pop);

    assign push_data.pc    = fetch_pc;
    assign push_data.instr = imem_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // A same-cycle pop still completes on redirect; the flush just discards the rest.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_instr  = out_valid ? head.instr : '0;
    assign out_pc     = out_valid ? head.pc    : '0;
    assign fifo_count = count;

endmodule
